// File: rtl/chash_poly_insert_pkg.sv
// Shared types and constants for the challenge-polynomial coefficient writer.
package chash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CHK,
        S_WR,
        S_FIN
    } state_t;

    // +1 / -1 encodings in the two residue channels
    localparam logic [23:0] CHASH_ONE_A = 24'h001041;
    localparam logic [23:0] CHASH_NEG_A = 24'hfbefc0;
    localparam logic [24:0] CHASH_ONE_B = 25'h1de0409;
    localparam logic [24:0] CHASH_NEG_B = 25'h01dfbf8;

    // Word offset of the challenge polynomial region in the RAM
    localparam logic [9:0]  CHASH_BASE  = 10'h300;

endpackage

// File: rtl/chash_poly_insert_lane_merge.sv
// Replaces one lane of a packed RAM word and reports whether that lane was zero.
module chash_lane_merge #(
    parameter int unsigned LANES = 2,
    parameter int unsigned W     = 24,
    parameter int unsigned LW    = 1
) (
    input  logic [LANES*W-1:0] word,
    input  logic [LW-1:0]      lane,
    input  logic [W-1:0]       val,
    output logic [LANES*W-1:0] merged,
    output logic               lane_zero
);

    // Select the addressed lane, substitute the value, test the old contents
    always_comb begin
        merged    = word;
        lane_zero = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane == LW'(i)) begin
                merged[i*W +: W] = val;
                lane_zero        = (word[i*W +: W] == '0);
            end
        end
    end

endmodule

// File: rtl/chash_poly_insert.sv
// Places sparse +/-1 challenge coefficients into the dual-residue polynomial RAM
// via one read-modify-write per index, reporting collisions and counting placements.
module chash_poly_insert
    import chash_pkg::*;
#(
    parameter int unsigned       LANES  = 2,
    parameter int unsigned       WA     = 24,
    parameter int unsigned       WB     = 25,
    parameter int unsigned       ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(CHASH_BASE),
    parameter int unsigned       RD_LAT = 1,
    parameter logic [WA-1:0]     ONE_A  = WA'(CHASH_ONE_A),
    parameter logic [WA-1:0]     NEG_A  = WA'(CHASH_NEG_A),
    parameter logic [WB-1:0]     ONE_B  = WB'(CHASH_ONE_B),
    parameter logic [WB-1:0]     NEG_B  = WB'(CHASH_NEG_B),
    parameter int unsigned       IDX_W  = ADDR_W + $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            weight,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  in_sign,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [LANES*WA-1:0]   rd_a,
    input  logic [LANES*WB-1:0]   rd_b,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [LANES*WA-1:0]   wr_a,
    output logic [LANES*WB-1:0]   wr_b,
    output logic                  res_valid,
    output logic                  res_coll,
    output logic [7:0]            count,
    output logic                  done
);

    localparam int unsigned LB        = $clog2(LANES);
    localparam int unsigned LW        = (LB > 0) ? LB : 1;
    localparam logic [1:0]  WAIT_LAST = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

    state_t               state, state_n;
    logic                 armed;
    logic [7:0]           weight_r;
    logic [IDX_W-1:0]     idx_q;
    logic                 sign_q;
    logic [1:0]           wcnt;
    logic [LANES*WA-1:0]  wa_q, merged_a;
    logic [LANES*WB-1:0]  wb_q, merged_b;
    logic                 zero_a, zero_b, hit, last, accept;
    logic [LW-1:0]        lane;
    logic [ADDR_W-1:0]    word_addr;

    if (LB > 0) begin : g_lane
        assign lane = idx_q[LB-1:0];
    end else begin : g_nolane
        assign lane = '0;
    end

    assign word_addr = BASE + idx_q[IDX_W-1:LB];
    assign hit       = zero_a & zero_b;
    assign last      = (count + 8'd1) == weight_r;
    assign accept    = (state == S_IDLE) & in_valid & in_ready & ~start;

    assign rd_addr = rd_en ? word_addr : '0;
    assign wr_addr = wr_en ? word_addr : '0;
    assign wr_a    = wr_en ? wa_q : '0;
    assign wr_b    = wr_en ? wb_q : '0;

    chash_lane_merge #(.LANES(LANES), .W(WA), .LW(LW)) u_merge_a (
        .word      (rd_a),
        .lane      (lane),
        .val       (sign_q ? NEG_A : ONE_A),
        .merged    (merged_a),
        .lane_zero (zero_a)
    );

    chash_lane_merge #(.LANES(LANES), .W(WB), .LW(LW)) u_merge_b (
        .word      (rd_b),
        .lane      (lane),
        .val       (sign_q ? NEG_B : ONE_B),
        .merged    (merged_b),
        .lane_zero (zero_b)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next state and strobes; start gates the write/result strobes so an
    // aborted RMW emits neither a write nor a result in the abort cycle
    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        res_valid = 1'b0;
        res_coll  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = armed & ~done;
                if (in_valid & in_ready) state_n = S_RD;
            end
            S_RD: begin
                rd_en   = 1'b1;
                state_n = (RD_LAT == 1) ? S_CHK : S_WAIT;
            end
            S_WAIT: begin
                if (wcnt == WAIT_LAST) state_n = S_CHK;
            end
            S_CHK: begin
                if (hit) begin
                    state_n = S_WR;
                end else begin
                    res_valid = ~start;
                    res_coll  = ~start;
                    state_n   = S_IDLE;
                end
            end
            S_WR: begin
                wr_en     = ~start;
                res_valid = ~start;
                state_n   = last ? S_FIN : S_IDLE;
            end
            S_FIN: begin
                state_n = S_FIN;
            end
            default: state_n = S_IDLE;
        endcase
        if (start) state_n = (weight == 8'd0) ? S_FIN : S_IDLE;
    end

    // Datapath: index latch, wait counter, merged words, count/done/armed
    always_ff @(posedge clk) begin
        if (!rst) begin
            armed    <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            weight_r <= '0;
            idx_q    <= '0;
            sign_q   <= 1'b0;
            wcnt     <= '0;
            wa_q     <= '0;
            wb_q     <= '0;
        end else if (start) begin
            weight_r <= weight;
            count    <= '0;
            armed    <= (weight != 8'd0);
            done     <= (weight == 8'd0);
        end else begin
            if (accept) begin
                idx_q  <= in_idx;
                sign_q <= in_sign;
            end
            if (state == S_RD)        wcnt <= '0;
            else if (state == S_WAIT) wcnt <= wcnt + 2'd1;
            if (state == S_CHK) begin
                wa_q <= merged_a;
                wb_q <= merged_b;
            end
            if (state == S_WR && count != weight_r) begin
                count <= count + 8'd1;
                if (last) begin
                    done  <= 1'b1;
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/chash_poly_insert.md
Name: chash_poly_insert

Overview:
- Parametrised successor to the two-lane challenge-polynomial writer. It places sparse ±1 challenge coefficients into the dual-residue (24-bit / 25-bit channel) polynomial RAM.
- For each challenge index it does a read-modify-write on one packed RAM word. The coefficient is written only if the target lane is zero in both channels; otherwise a collision is reported.
- It counts placed coefficients against a programmable weight and signals done. It sits between the challenge-hash sampler and the polynomial RAM.

Parameters:
- LANES, 2, coefficients packed per RAM word (power of 2, 1..8)
- WA, 24, channel-A residue width
- WB, 25, channel-B residue width
- ADDR_W, 10, RAM word-address width
- BASE, 10'h300, word offset of the challenge polynomial region
- RD_LAT, 1, RAM read latency in cycles (1..3)
- ONE_A, 24'h001041, channel-A encoding of +1
- NEG_A, 24'hfbefc0, channel-A encoding of -1
- ONE_B, 25'h1de0409, channel-B encoding of +1
- NEG_B, 25'h01dfbf8, channel-B encoding of -1
- IDX_W, ADDR_W+log2(LANES), coefficient index width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, ACTIVE-LOW (rst==0 resets)
- start  in  1  pulse; loads weight, clears count, arms block
- weight  in  8  number of coefficients to place (0..255)
- in_valid  in  1  challenge index valid
- in_ready  out  1  block can accept an index
- in_idx  in  IDX_W  coefficient index
- in_sign  in  1  1 = -1, 0 = +1
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_a  in  LANES*WA  channel-A read word
- rd_b  in  LANES*WB  channel-B read word
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_a  out  LANES*WA  channel-A write word
- wr_b  out  LANES*WB  channel-B write word
- res_valid  out  1  one-cycle result pulse per accepted index
- res_coll  out  1  qualifies res_valid: 1 = collision (not written)
- count  out  8  coefficients placed so far
- done  out  1  level; count==weight

Behaviour:
- Reset (rst==0 at posedge): state IDLE, all outputs 0, count=0, done=0, armed=0. Reset mid-operation aborts any pending write: no wr_en after reset.
- FSM states: IDLE, RD, WAIT, CHK, WR, FIN.
- IDLE: in_ready = armed & ~done. A handshake (in_valid & in_ready) latches idx and sign, then goes to RD.
- RD: rd_en=1 for one cycle. rd_addr = BASE + (idx >> log2(LANES)), truncated to ADDR_W (wraps). lane = idx[log2(LANES)-1:0]. Next state is WAIT, or CHK directly if RD_LAT==1.
- WAIT: counts RD_LAT-1 cycles, then CHK. rd data is valid and sampled in CHK (RD_LAT cycles after rd_en).
- CHK: registers the read words. hit = (rd_a lane slice == 0) & (rd_b lane slice == 0). On hit, next state is WR. On miss, pulse res_valid with res_coll=1, count unchanged, next state IDLE.
- WR: wr_en=1 for one cycle, wr_addr = rd_addr. wr_a/wr_b = the read words with only the lane slice replaced by {NEG_A,NEG_B} if sign else {ONE_A,ONE_B}; other lanes pass through unchanged. Same cycle: res_valid=1, res_coll=0, count+1. Next state is FIN if count+1==weight, else IDLE.
- FIN: done=1, in_ready=0, armed=0. Held until start.
- Latency: handshake to wr_en = RD_LAT+2 cycles. Throughput is one index per RD_LAT+3 cycles; no overlapping RMW, so there is no same-word hazard.
- start: accepted in any state. It aborts an in-flight index (no write, no res_valid), sets count=0 and armed=1. done = (weight==0); with weight==0 the block goes to FIN immediately.
- start and in_valid in the same cycle: start wins and the index is not accepted.
- count saturates at weight. res_valid never asserts without a prior handshake.
- rd_addr, wr_addr, wr_a and wr_b read 0 whenever their strobe is low.

Decomposition:
- Shared package chash_pkg: state enum, the ±1 residue constants for both channels, the BASE region offset.
- One natural sub-module: chash_lane_merge (combinational). Inputs: packed word, lane, value. Outputs: merged word and lane-zero flag. Instantiated once per channel (WA and WB).

Test Plan:
- Reset: hold rst=0 3 cycles mid-RMW -> all outputs 0, no wr_en, in_ready=0 until start.
- Basic place: defaults, start weight=2, idx=5 sign=0, RAM word 0x302 zero -> rd_addr=0x302. Write shows wr_addr=0x302, wr_a[47:24]=0x001041, wr_b[49:25]=0x1de0409, low lane unchanged, count=1.
- Negative lane 0: idx=4 sign=1 with RAM 0x302 lane1 already set -> wr_a={0x001041,0xfbefc0}, wr_b={0x1de0409,0x01dfbf8}. count=2, done=1, in_ready=0.
- Collision: idx=5 again (lane1 of 0x302 non-zero in channel B only) -> res_valid=1, res_coll=1, no wr_en, count unchanged.
- Wrap and latency: RD_LAT=3, idx=0x7FF -> rd_addr=(0x300+0x3FF)&0x3FF=0x2FF. wr_en exactly 5 cycles after handshake.
- start mid-RMW and weight=0: start during WAIT -> no write, count=0. start with weight=0 -> done=1 next cycle, in_ready=0.
